// File: rtl/bcd_entry_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_entry_buffer_pkg
// Brief    : Shared calculator constants: key codes, operand size, key FSM states.
// Revision : 1.0
// ============================================================================
package bcd_entry_buffer_pkg;

    localparam int DIGITS_DEFAULT = 10;

    localparam logic [3:0] KEY_BKSP = 4'hA;
    localparam logic [3:0] KEY_CLR  = 4'hB;
    localparam logic [3:0] KEY_SIGN = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HELD  = 2'd2
    } key_state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_entry_buffer_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : bcd_entry_buffer_sync_debounce
// Brief    : 2-FF synchronizer plus press/release debounce FSM; one-cycle accept strobe.
// Revision : 1.0
// ============================================================================
module bcd_entry_buffer_sync_debounce
    import bcd_entry_buffer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 17
) (
    input  logic clk,
    input  logic reset_button,
    input  logic i_key,
    output logic o_accept
);

    // The IDLE cycle that first sees the key counts as the first stable cycle,
    // so PRESS finishes one count early to keep latency at 2 + DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] c_PRESS_LAST   = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] c_RELEASE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    key_state_t       r_state;
    key_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_accept;

    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_meta  <= i_key;
            r_sync  <= r_meta;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync) begin
                    w_state_next = ST_PRESS;
                    w_cnt_next   = '0;
                end
            end
            ST_PRESS: begin
                if (!r_sync) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_PRESS_LAST) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_HELD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (r_sync) begin
                    w_cnt_next = '0;
                end else if (r_cnt == c_RELEASE_LAST) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_accept = w_accept;

endmodule
`default_nettype wire

// File: rtl/bcd_entry_buffer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_entry_buffer
// Brief    : Keypad operand entry: debounced keys build a signed packed-BCD value.
// Revision : 1.0
// ============================================================================
module bcd_entry_buffer
    import bcd_entry_buffer_pkg::*;
#(
    parameter int DIGITS          = DIGITS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 17
) (
    input  logic                clk,
    input  logic                reset_button,
    input  logic                key_down,
    input  logic [3:0]          key_code,
    input  logic                enter_button,
    input  logic                enable_switch,
    output logic [4*DIGITS-1:0] in_val,
    output logic [3:0]          digit_count,
    output logic                o_sign,
    output logic                overflow,
    output logic                key_pulse
);

    localparam logic [3:0] c_DIGITS = 4'(DIGITS);

    logic r_ent_meta;
    logic r_ent_sync;
    logic r_ent_prev;
    logic w_enter_rise;
    logic w_accept;
    logic w_apply;

    bcd_entry_buffer_sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk          (clk),
        .reset_button (reset_button),
        .i_key        (key_down),
        .o_accept     (w_accept)
    );

    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            r_ent_meta <= 1'b0;
            r_ent_sync <= 1'b0;
            r_ent_prev <= 1'b0;
        end else begin
            r_ent_meta <= enter_button;
            r_ent_sync <= r_ent_meta;
            r_ent_prev <= r_ent_sync;
        end
    end

    assign w_enter_rise = r_ent_sync & ~r_ent_prev;
    assign w_apply      = w_accept & enable_switch & (key_code <= KEY_SIGN);

    // Enter clear takes priority over a coincident key action; the pulse still fires.
    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            in_val      <= '0;
            digit_count <= '0;
            o_sign      <= 1'b0;
            overflow    <= 1'b0;
            key_pulse   <= 1'b0;
        end else begin
            key_pulse <= w_apply;
            if (w_enter_rise) begin
                in_val      <= '0;
                digit_count <= '0;
                o_sign      <= 1'b0;
                overflow    <= 1'b0;
            end else if (w_apply) begin
                if (key_code <= 4'd9) begin
                    if (!(digit_count == 4'd0 && key_code == 4'd0)) begin
                        if (digit_count < c_DIGITS) begin
                            in_val      <= {in_val[4*DIGITS-5:0], key_code};
                            digit_count <= digit_count + 4'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end else begin
                    case (key_code)
                        KEY_BKSP: begin
                            if (digit_count != 4'd0) begin
                                in_val      <= in_val >> 4;
                                digit_count <= digit_count - 4'd1;
                                overflow    <= 1'b0;
                                if (digit_count == 4'd1) begin
                                    o_sign <= 1'b0;
                                end
                            end
                        end
                        KEY_CLR: begin
                            in_val      <= '0;
                            digit_count <= '0;
                            o_sign      <= 1'b0;
                            overflow    <= 1'b0;
                        end
                        KEY_SIGN: begin
                            if (digit_count != 4'd0) begin
                                o_sign <= ~o_sign;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_entry_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_entry_buffer
// Brief    : Self-checking bench for bcd_entry_buffer with a digit-list reference model.
// Revision : 1.0
// ============================================================================
module tb_bcd_entry_buffer;

    localparam int DEB = 4;
    localparam int ND  = 10;

    logic            clk;
    logic            reset_button;
    logic            key_down;
    logic [3:0]      key_code;
    logic            enter_button;
    logic            enable_switch;
    logic [4*ND-1:0] in_val;
    logic [3:0]      digit_count;
    logic            o_sign;
    logic            overflow;
    logic            key_pulse;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: q[0] is the most recently entered (least significant) digit.
    int   q[$];
    logic m_sign = 1'b0;
    logic m_ovf  = 1'b0;

    bcd_entry_buffer #(
        .DIGITS          (ND),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (17)
    ) dut (
        .clk           (clk),
        .reset_button  (reset_button),
        .key_down      (key_down),
        .key_code      (key_code),
        .enter_button  (enter_button),
        .enable_switch (enable_switch),
        .in_val        (in_val),
        .digit_count   (digit_count),
        .o_sign        (o_sign),
        .overflow      (overflow),
        .key_pulse     (key_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*ND-1:0] m_val();
        logic [4*ND-1:0] v = '0;
        for (int i = 0; i < q.size(); i++) v = v | (40'(q[i]) << (4 * i));
        return v;
    endfunction

    task automatic model_key(input logic [3:0] code);
        if (code <= 4'd9) begin
            if (q.size() == 0 && code == 4'd0) begin
                // leading zero: nothing to record
            end else if (q.size() < ND) begin
                q.push_front(int'(code));
            end else begin
                m_ovf = 1'b1;
            end
        end else if (code == 4'hA) begin
            if (q.size() > 0) begin
                void'(q.pop_front());
                m_ovf = 1'b0;
                if (q.size() == 0) m_sign = 1'b0;
            end
        end else if (code == 4'hB) begin
            q.delete();
            m_sign = 1'b0;
            m_ovf  = 1'b0;
        end else if (code == 4'hC) begin
            if (q.size() > 0) m_sign = ~m_sign;
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_val"},  64'(in_val),      64'(m_val()));
        chk({tag, "_cnt"},  64'(digit_count), 64'(q.size()));
        chk({tag, "_sign"}, 64'(o_sign),      64'(m_sign));
        chk({tag, "_ovf"},  64'(overflow),    64'(m_ovf));
    endtask

    // Holds key_down for 'hold' sampled cycles (optionally with a low dip), then
    // leaves it low long enough for the release debounce to complete.
    task automatic press(input logic [3:0] code, input int hold, input int dip_at,
                         input int dip_len, output int npulse, output int first_at);
        npulse   = 0;
        first_at = -1;
        @(posedge clk); #1;
        key_code = code;
        key_down = 1'b1;
        for (int c = 1; c <= hold + 12; c++) begin
            @(posedge clk); #1;
            if (key_pulse) begin
                npulse++;
                if (first_at < 0) first_at = c;
            end
            if (dip_at > 0 && c == dip_at) key_down = 1'b0;
            if (dip_at > 0 && c == dip_at + dip_len) key_down = 1'b1;
            if (c == hold) key_down = 1'b0;
        end
    endtask

    task automatic do_press(input logic [3:0] code, input int hold, input logic en,
                            input int dip_at, input int dip_len, input string tag);
        int  np, fa;
        bit  acted;
        enable_switch = en;
        press(code, hold, dip_at, dip_len, np, fa);
        acted = (hold >= DEB) && en && (code <= 4'hC);
        chk({tag, "_npulse"}, 64'(np), acted ? 64'd1 : 64'd0);
        if (acted) begin
            chk({tag, "_lat"}, 64'(fa), 64'(2 + DEB));
            model_key(code);
        end
        chk_state(tag);
    endtask

    task automatic do_enter(input string tag);
        @(posedge clk); #1;
        enter_button = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_pre"}, 64'(in_val), 64'(m_val()));
        @(posedge clk); #1;
        q.delete();
        m_sign = 1'b0;
        m_ovf  = 1'b0;
        chk_state({tag, "_clr"});
        enter_button = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int np, fa;
        reset_button  = 1'b1;
        key_down      = 1'b0;
        key_code      = 4'd0;
        enter_button  = 1'b0;
        enable_switch = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_state("reset");
        chk("reset_pulse", 64'(key_pulse), 64'd0);
        reset_button = 1'b0;
        repeat (2) @(posedge clk);

        do_press(4'd1, 5, 1'b1, 0, 0, "p1");
        do_press(4'd2, 4, 1'b1, 0, 0, "p2");
        do_press(4'd3, 6, 1'b1, 0, 0, "p3");
        chk("v123", 64'(in_val), 64'h123);
        do_press(4'hB, 5, 1'b1, 0, 0, "clr");

        do_press(4'd0, 5, 1'b1, 0, 0, "z0");
        do_press(4'd0, 5, 1'b1, 0, 0, "z1");
        do_press(4'd7, 5, 1'b1, 0, 0, "p7");
        chk("v7", 64'(in_val), 64'h7);
        do_press(4'hB, 5, 1'b1, 0, 0, "clr2");

        for (int i = 0; i < ND; i++) do_press(4'd9, 4, 1'b1, 0, 0, "nine");
        do_press(4'd5, 5, 1'b1, 0, 0, "full5");
        chk("full_val", 64'(in_val), 64'h9999999999);
        chk("full_ovf", 64'(overflow), 64'd1);
        do_press(4'hA, 5, 1'b1, 0, 0, "bksp");
        chk("bksp_val", 64'(in_val), 64'h0999999999);

        do_press(4'd4, 3, 1'b1, 0, 0, "glitch");
        do_press(4'd4, 12, 1'b1, 7, 2, "dip");
        do_press(4'hB, 5, 1'b1, 0, 0, "clr3");

        do_press(4'd4, 5, 1'b1, 0, 0, "p4");
        do_press(4'd2, 5, 1'b1, 0, 0, "p42");
        do_press(4'hC, 5, 1'b1, 0, 0, "sign");
        chk("sign_set", 64'(o_sign), 64'd1);
        do_enter("enter");

        // Reset in the middle of a press, key held through reset release.
        do_press(4'd5, 5, 1'b1, 0, 0, "p5");
        @(posedge clk); #1;
        key_code = 4'd3;
        key_down = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset_button = 1'b1;
        #1;
        q.delete();
        m_sign = 1'b0;
        m_ovf  = 1'b0;
        chk_state("async_rst");
        chk("async_rst_pulse", 64'(key_pulse), 64'd0);
        @(posedge clk); #1;
        reset_button = 1'b0;
        np = 0;
        fa = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (key_pulse) begin
                np++;
                if (fa < 0) fa = c;
            end
            if (c == 8) key_down = 1'b0;
        end
        chk("post_rst_npulse", 64'(np), 64'd1);
        chk("post_rst_lat", 64'(fa), 64'(2 + DEB));
        model_key(4'd3);
        chk_state("post_rst");

        do_press(4'd8, 5, 1'b0, 0, 0, "dis8");

        for (int i = 0; i < 50; i++) begin
            logic [3:0] code;
            code = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) code = 4'($urandom_range(1, 9));
            do_press(code, int'($urandom_range(2, 7)), ($urandom_range(0, 7) != 0),
                     0, 0, "rand");
            if (i % 12 == 11) begin
                enable_switch = 1'($urandom_range(0, 1));
                do_enter("rand_enter");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
